// File: rtl/md_sequencer_if.sv
// EX-stage multiply/divide request and HI/LO read-back bundle.
// The EX side is master, the sequencer is slave.
interface md_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start_E;
    logic [1:0]       MD_Op_E;
    logic [WIDTH-1:0] Src_AE;
    logic [WIDTH-1:0] Src_BE;
    logic             MT_HI_E;
    logic             MT_LO_E;
    logic             Read_HiLo_E;
    logic             Read_Sel_E;
    logic [WIDTH-1:0] HiLo_Out_E;
    logic             MD_Busy;
    logic             Stall_MD;
    logic             Div_By_Zero;

    modport master (
        output Start_E, MD_Op_E, Src_AE, Src_BE,
        output MT_HI_E, MT_LO_E, Read_HiLo_E, Read_Sel_E,
        input  HiLo_Out_E, MD_Busy, Stall_MD, Div_By_Zero
    );

    modport slave (
        input  Start_E, MD_Op_E, Src_AE, Src_BE,
        input  MT_HI_E, MT_LO_E, Read_HiLo_E, Read_Sel_E,
        output HiLo_Out_E, MD_Busy, Stall_MD, Div_By_Zero
    );
endinterface

// File: rtl/md_sequencer.sv
// Iterative 32-step multiply / restoring divide unit owning HI and LO.
// Signed ops run on magnitudes; signs are re-applied in the FIX state.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    md_sequencer_if.slave md
);
    localparam int W = WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           mul_q, mul_d;
    logic           div0_q, div0_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           sgn, neg_a, neg_b;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     madd, rsh, dif;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot, rem;

    assign sgn   = ~md.MD_Op_E[0];
    assign neg_a = sgn & md.Src_AE[W-1];
    assign neg_b = sgn & md.Src_BE[W-1];
    assign abs_a = neg_a ? -md.Src_AE : md.Src_AE;
    assign abs_b = neg_b ? -md.Src_BE : md.Src_BE;

    // Multiply: multiplier LSB gates the add into the upper half, then shift.
    assign madd = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : '0);
    // Divide: partial remainder in the upper half, quotient fills the lower.
    assign rsh  = {acc_q[2*W-1:W], a_q[W-1]};
    assign dif  = rsh - {1'b0, b_q};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quot = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        mul_d   = mul_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (md.Start_E) begin
                    a_d    = abs_a;
                    b_d    = abs_b;
                    neg_d  = neg_a ^ neg_b;
                    rneg_d = neg_a;
                    acc_d  = '0;
                    cnt_d  = '0;
                    mul_d  = ~md.MD_Op_E[1];
                    div0_d = 1'b0;
                    if (!md.MD_Op_E[1]) begin
                        state_d = S_MUL;
                    end else if (md.Src_BE == '0) begin
                        state_d = S_FIX;
                        div0_d  = 1'b1;
                        a_d     = md.Src_AE;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    if (md.MT_HI_E) hi_d = md.Src_AE;
                    if (md.MT_LO_E) lo_d = md.Src_AE;
                end
            end
            S_MUL: begin
                acc_d = {madd, acc_q[W-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {dif[W] ? rsh[W-1:0] : dif[W-1:0],
                         acc_q[W-2:0], ~dif[W]};
                a_d   = a_q << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (div0_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else if (mul_q) begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mul_q   <= 1'b0;
            div0_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            mul_q   <= mul_d;
            div0_q  <= div0_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.MD_Busy     = (state_q != S_IDLE);
    assign md.Div_By_Zero = dz_q;
    assign md.HiLo_Out_E  = md.Read_Sel_E ? hi_q : lo_q;
    assign md.Stall_MD    = md.MD_Busy & (md.Start_E | md.Read_HiLo_E |
                                           md.MT_HI_E | md.MT_LO_E);
endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-step shift-add multiply or restoring divide alongside the main ALU. Owns the HI/LO registers and serves MTHI/MTLO/MFHI/MFLO. Drives a stall to the hazard unit whenever an EX instruction needs the unit or HI/LO while an operation is in flight.

## Interface
- WIDTH, 32: operand width. Only 32 is supported.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Start_E  in  1  a valid mult/div instruction is in EX.
- MD_Op_E  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Src_AE  in  32  rs operand; dividend or multiplicand; MTHI/MTLO data.
- Src_BE  in  32  rt operand; divisor or multiplier.
- MT_HI_E  in  1  MTHI in EX.
- MT_LO_E  in  1  MTLO in EX.
- Read_HiLo_E  in  1  MFHI or MFLO in EX.
- Read_Sel_E  in  1  read select: 1 returns HI, 0 returns LO.
- HiLo_Out_E  out  32  combinational HI or LO per Read_Sel_E.
- MD_Busy  out  1  registered; high while an operation is in flight.
- Stall_MD  out  1  combinational stall request to the hazard unit.
- Div_By_Zero  out  1  registered one-cycle pulse when a divide-by-zero completes.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- Accept rule: Start_E is accepted only in IDLE. On acceptance:
  - latch the absolute values of both operands (signed ops only);
  - latch result sign flags: quotient/product sign = sA^sB; remainder sign = sA;
  - clear the 64-bit accumulator and the 5-bit step counter;
  - go to MUL for MULT/MULTU, or to DIV for DIV/DIVU.
- Divide by zero (Src_BE==0 on a DIV/DIVU start): go directly to FIX with a div0 flag.
  - Result: HI=Src_AE as latched, LO=32'hFFFFFFFF.
  - Div_By_Zero pulses in the cycle after FIX.
- MUL: each cycle, if multiplier bit0 is 1, add the multiplicand to the upper half. Shift the 64-bit accumulator right by 1. After 32 steps (counter 31 → wrap), go to FIX.
- DIV: restoring algorithm, one quotient bit per cycle, 32 steps, then go to FIX.
- FIX: apply two's-complement negation per the sign flags, write HI/LO, then return to IDLE.
  - MUL: {HI,LO} = 64-bit product.
  - DIV: LO = quotient, HI = remainder.
- Arithmetic is modulo 2^32. 0x80000000 / -1 gives LO=0x80000000, HI=0, with no exception.
- MT_HI_E/MT_LO_E in IDLE write Src_AE to HI/LO at the clock edge.
- Priority in IDLE: Start_E overrides MT_*. Both together is illegal; Start wins.
- Stall_MD = MD_Busy & (Start_E | Read_HiLo_E | MT_HI_E | MT_LO_E).
  - While stalled, EX holds its instruction and inputs are re-presented.
  - Inputs presented while busy are ignored; nothing is queued.
- HiLo_Out_E always reflects the current HI/LO registers. There is no bypass; the stall guarantees freshness.

## Timing
- Reset: state IDLE; HI=LO=0; MD_Busy=0; Div_By_Zero=0; counter=0; HiLo_Out_E=0.
- Start accepted at edge T:
  - MD_Busy is high for cycles T+1..T+33 (32 iterate cycles plus FIX).
  - HI/LO are written at edge T+34.
  - MD_Busy=0 in cycle T+34.
- Divide by zero: MD_Busy is high in cycle T+1 only (FIX). HI/LO are written at edge T+2, and Div_By_Zero is high in cycle T+2.
- A stalled MFHI/MFLO sees the new value in the first cycle MD_Busy=0. A back-to-back Start is accepted at that same edge.
- MTHI at edge T followed by MFHI in cycle T+1: returns the new value.
- rst asserted mid-operation: abort at that edge. Return to IDLE and clear HI/LO; no partial result is written.
- The counter wraps from 31 to 0 only on the transition into FIX.

## Test plan
- MULT with A=0xFFFFFFFE (−2), B=3: after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. MD_Busy high for exactly 33 cycles.
- MULTU with A=B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. Repeat as MULT: HI=0, LO=1.
- DIV with A=−7, B=2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIV with A=0x80000000, B=−1: LO=0x80000000, HI=0.
- DIVU with A=100, B=0: MD_Busy high for 1 cycle. Then HI=100, LO=0xFFFFFFFF, and Div_By_Zero pulses once.
- DIVU 100/7 immediately followed by MFLO: Stall_MD high for all 33 busy cycles, then HiLo_Out_E=14 with Read_Sel_E=0. MFHI returns 2.
  - Start held during busy is not re-accepted until idle.
- MTLO 0x1234 then MFLO: returns 0x1234 with no stall.
  - Assert rst in cycle T+10 of a MULT: MD_Busy=0, HI=LO=0 next cycle, and no later write occurs.
